i2c_control_unit: RTL and testbench

Sequencing controller for the I2C master datapath. It generates the SCL waveform from a baud divider and drives the data unit's control strobes: WriteLoad, ReadorWrite, ShiftorHold, Select and StartStopAck. It also supplies the byte to be shifted out on SentData. Each Go request runs one single-byte transaction: START, address+R/W, ACK, data byte, ACK/NACK, STOP.

---
 rtl/i2c_control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_control_unit.sv
// I2C master sequencing controller: SCL generation plus data-unit strobes for one
// single-byte transaction per Go. Optional SCL clock stretching under I2C_CLOCK_STRETCH_EN.
module i2c_control_unit #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 100_000
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       Go,
    input  logic       RW,
    input  logic [6:0] Address,
    input  logic [7:0] WriteData,
    input  logic       SDAIn,
    input  logic       SCLIn,
    output logic       SCL,
    output logic       WriteLoad,
    output logic       ReadorWrite,
    output logic       ShiftorHold,
    output logic       Select,
    output logic       StartStopAck,
    output logic [7:0] SentData,
    output logic       Busy,
    output logic       Done,
    output logic       AckError
);

    localparam int QUARTER_RAW = CLOCK_FREQUENCY / (4 * BAUD_RATE);
    localparam int QUARTER     = (QUARTER_RAW < 1) ? 1 : QUARTER_RAW;
    localparam int CNT_W       = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       q, q_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic             rw_lat, rw_nxt;
    logic [7:0]       wdata_lat, wdata_nxt;
    logic [7:0]       sent_nxt;
    logic             ack_err_nxt;
    logic             scl_nxt, wl_nxt, rdwr_nxt, sh_nxt, sel_nxt, ssa_nxt;
    logic             busy_nxt, done_nxt;
    logic             hold, advance, quarter_end, bit_end, last_nxt;

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low freezes the quarter counter during the high phase.
    always_comb begin
        hold = 1'b0;
        if (state != IDLE && !SCLIn)
            hold = q[1] || (state == STOP && q != 2'd0);
    end
`else
    logic unused_sclin;
    assign unused_sclin = SCLIn;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            q            <= 2'd0;
            cnt          <= '0;
            bit_idx      <= 3'd0;
            rw_lat       <= 1'b0;
            wdata_lat    <= 8'd0;
            SentData     <= 8'd0;
            AckError     <= 1'b0;
            SCL          <= 1'b1;
            StartStopAck <= 1'b1;
            ReadorWrite  <= 1'b0;
            Select       <= 1'b0;
            ShiftorHold  <= 1'b0;
            WriteLoad    <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            q            <= q_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_nxt;
            rw_lat       <= rw_nxt;
            wdata_lat    <= wdata_nxt;
            SentData     <= sent_nxt;
            AckError     <= ack_err_nxt;
            SCL          <= scl_nxt;
            StartStopAck <= ssa_nxt;
            ReadorWrite  <= rdwr_nxt;
            Select       <= sel_nxt;
            ShiftorHold  <= sh_nxt;
            WriteLoad    <= wl_nxt;
            Busy         <= busy_nxt;
            Done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        q_nxt       = q;
        cnt_nxt     = cnt;
        bit_nxt     = bit_idx;
        rw_nxt      = rw_lat;
        wdata_nxt   = wdata_lat;
        sent_nxt    = SentData;
        ack_err_nxt = AckError;
        done_nxt    = 1'b0;
        advance     = (state != IDLE) && !hold;
        quarter_end = (cnt == CNT_LAST);
        bit_end     = quarter_end && (q == 2'd3);

        if (state == IDLE) begin
            if (Go) begin
                state_nxt   = START;
                q_nxt       = 2'd0;
                cnt_nxt     = '0;
                bit_nxt     = 3'd0;
                rw_nxt      = RW;
                wdata_nxt   = WriteData;
                sent_nxt    = {Address, RW};
                ack_err_nxt = 1'b0;
            end
        end else if (advance) begin
            if (quarter_end) begin
                cnt_nxt = '0;
                q_nxt   = q + 2'd1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            // Slave acknowledge is sampled late in the SCL high phase.
            if ((state == ADDR_ACK || (state == DATA_ACK && !rw_lat)) &&
                q == 2'd2 && quarter_end) begin
                if (SDAIn)
                    ack_err_nxt = 1'b1;
                else if (state == ADDR_ACK)
                    sent_nxt = wdata_lat;
            end
            if (bit_end) begin
                case (state)
                    START: begin
                        state_nxt = ADDR;
                        bit_nxt   = 3'd0;
                    end
                    ADDR: begin
                        bit_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state_nxt = ADDR_ACK;
                    end
                    ADDR_ACK: begin
                        state_nxt = AckError ? STOP : DATA;
                        bit_nxt   = 3'd0;
                    end
                    DATA: begin
                        bit_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state_nxt = DATA_ACK;
                    end
                    DATA_ACK: state_nxt = STOP;
                    STOP: begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

        // Outputs are decoded from the position being entered so they register in step with it.
        last_nxt = (cnt_nxt == CNT_LAST);
        scl_nxt  = 1'b1;
        ssa_nxt  = 1'b1;
        rdwr_nxt = 1'b0;
        sel_nxt  = 1'b0;
        wl_nxt   = 1'b0;
        sh_nxt   = 1'b0;
        case (state_nxt)
            START: begin
                rdwr_nxt = 1'b1;
                ssa_nxt  = !q_nxt[1];
                wl_nxt   = (q_nxt == 2'd3) && last_nxt;
            end
            ADDR: begin
                scl_nxt  = q_nxt[1];
                sel_nxt  = 1'b1;
                rdwr_nxt = 1'b1;
                sh_nxt   = (q_nxt == 2'd0) && last_nxt && (bit_nxt != 3'd0);
            end
            ADDR_ACK: begin
                scl_nxt = q_nxt[1];
                wl_nxt  = (q_nxt == 2'd3) && last_nxt && !ack_err_nxt;
            end
            DATA: begin
                scl_nxt = q_nxt[1];
                sel_nxt = 1'b1;
                if (rw_nxt) begin
                    sh_nxt = (q_nxt == 2'd2) && last_nxt;
                end else begin
                    rdwr_nxt = 1'b1;
                    sh_nxt   = (q_nxt == 2'd0) && last_nxt && (bit_nxt != 3'd0);
                end
            end
            DATA_ACK: begin
                scl_nxt  = q_nxt[1];
                rdwr_nxt = rw_nxt;
            end
            STOP: begin
                rdwr_nxt = 1'b1;
                scl_nxt  = (q_nxt != 2'd0);
                ssa_nxt  = q_nxt[1];
            end
            default: ;
        endcase
        // A held position must not repeat its strobe.
        if (hold) begin
            wl_nxt = 1'b0;
            sh_nxt = 1'b0;
        end
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_i2c_control_unit.sv
// Self-checking bench for i2c_control_unit with QUARTER=4 (16 clocks per bit):
// vector table of transactions, expected records queued at Go and popped at Done.
module tb_i2c_control_unit;

    localparam int Q  = 4;
    localparam int QB = 4 * Q;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam int STRETCH_DONE = 330;
`else
    localparam int STRETCH_DONE = 320;
`endif

    logic       clock;
    logic       Reset;
    logic       Go;
    logic       RW;
    logic [6:0] Address;
    logic [7:0] WriteData;
    logic       SDAIn;
    logic       SCLIn;
    logic       SCL, WriteLoad, ReadorWrite, ShiftorHold, Select, StartStopAck;
    logic [7:0] SentData;
    logic       Busy, Done, AckError;

    i2c_control_unit #(
        .CLOCK_FREQUENCY(16),
        .BAUD_RATE      (1)
    ) dut (
        .clock       (clock),
        .Reset       (Reset),
        .Go          (Go),
        .RW          (RW),
        .Address     (Address),
        .WriteData   (WriteData),
        .SDAIn       (SDAIn),
        .SCLIn       (SCLIn),
        .SCL         (SCL),
        .WriteLoad   (WriteLoad),
        .ReadorWrite (ReadorWrite),
        .ShiftorHold (ShiftorHold),
        .Select      (Select),
        .StartStopAck(StartStopAck),
        .SentData    (SentData),
        .Busy        (Busy),
        .Done        (Done),
        .AckError    (AckError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       nack_addr;
        logic       nack_data;
        int         exp_done;
        int         exp_wl;
        int         exp_sh;
        logic       exp_err;
        logic [7:0] exp_sent0;
        logic [7:0] exp_sent1;
    } vec_t;

    vec_t vecs[5];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [16:0] RESET_OUTS = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    function automatic logic [16:0] outs();
        return {SCL, StartStopAck, ReadorWrite, Select, ShiftorHold, WriteLoad,
                Busy, Done, AckError, SentData};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Shift strobes fall on the last clock of q0 (transmit) or q2 (receive) of their bit.
    function automatic int exp_shsum(input logic rw, input logic nack_addr);
        int s = 0;
        for (int n = 2; n <= 8; n++) s += QB * n + (Q - 1);
        if (!nack_addr) begin
            for (int n = 10; n <= 17; n++) begin
                if (rw) s += QB * n + 2 * Q + (Q - 1);
                else if (n >= 11) s += QB * n + (Q - 1);
            end
        end
        return s;
    endfunction

    // Caller is positioned at a falling edge; Go is sampled at the next rising edge.
    task automatic run_txn(input vec_t v, input int st_at, input int st_len);
        int   wl = 0, sh = 0, shsum = 0, both = 0, scl_bad = 0, ctl_bad = 0;
        int   done_k = -1, stop_n, n, j;
        logic [7:0] sent0 = 8'h00, sent1 = 8'h00;
        logic exp_scl, exp_ssa, busy_at_done = 1'b1;
        vec_t e;
        sb.push_back(v);
        stop_n    = v.nack_addr ? 10 : 19;
        RW        = v.rw;
        Address   = v.addr;
        WriteData = v.wdata;
        Go        = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 1000 && done_k < 0; k++) begin
            @(negedge clock);
            if (k == 2) Go = 1'b0;
            SDAIn = v.nack_addr | (v.nack_data && k >= 18 * QB);
            SCLIn = (st_len > 0 && k >= st_at && k < st_at + st_len) ? 1'b0 : 1'b1;
            if (k == 0) chk("start_busy", 32'({Busy, Done}), 32'(2'b10));
            if (WriteLoad) begin
                if (wl == 0) sent0 = SentData;
                else sent1 = SentData;
                wl++;
            end
            if (ShiftorHold) begin
                sh++;
                shsum += k;
            end
            if (WriteLoad && ShiftorHold) both++;
            if (Done) begin
                done_k       = k;
                busy_at_done = Busy;
            end else if (st_len == 0) begin
                n       = k / QB;
                j       = (k % QB) / Q;
                exp_scl = (n == 0) ? 1'b1 : (n == stop_n) ? (j != 0) : (j >= 2);
                if (SCL !== exp_scl) scl_bad++;
                exp_ssa = (j < 2);
                if (n == 0 && (StartStopAck !== exp_ssa || Select !== 1'b0 || ReadorWrite !== 1'b1))
                    ctl_bad++;
                if (n >= 1 && n <= 8 && (Select !== 1'b1 || ReadorWrite !== 1'b1)) ctl_bad++;
                if (n == 9 && (Select !== 1'b0 || ReadorWrite !== 1'b0)) ctl_bad++;
                if (!v.nack_addr && n >= 10 && n <= 17 &&
                    (Select !== 1'b1 || ReadorWrite !== !v.rw)) ctl_bad++;
                if (!v.nack_addr && n == 18 &&
                    (Select !== 1'b0 || ReadorWrite !== v.rw || (v.rw && StartStopAck !== 1'b1)))
                    ctl_bad++;
                exp_ssa = (j >= 2);
                if (n == stop_n && (StartStopAck !== exp_ssa || Select !== 1'b0 || ReadorWrite !== 1'b1))
                    ctl_bad++;
            end
        end
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: got empty queue want one record");
            bad++;
            total++;
        end else begin
            e = sb.pop_front();
            chk("done_latency", 32'(done_k), 32'(e.exp_done));
            chk("busy_at_done", 32'(busy_at_done), 32'(0));
            chk("writeload_count", 32'(wl), 32'(e.exp_wl));
            chk("shift_count", 32'(sh), 32'(e.exp_sh));
            chk("ack_error", 32'(AckError), 32'(e.exp_err));
            chk("sent_first", 32'(sent0), 32'(e.exp_sent0));
            if (e.exp_wl == 2) chk("sent_second", 32'(sent1), 32'(e.exp_sent1));
            chk("load_shift_overlap", 32'(both), 32'(0));
            if (st_len == 0) begin
                chk("shift_timing", 32'(shsum), 32'(exp_shsum(e.rw, e.nack_addr)));
                chk("scl_wave", 32'(scl_bad), 32'(0));
                chk("ctl_levels", 32'(ctl_bad), 32'(0));
            end
        end
    endtask

    initial begin
        int busy_seen = 0;
        vec_t sv;
        Go = 1'b0; RW = 1'b0; Address = 7'd0; WriteData = 8'd0;
        SDAIn = 1'b0; SCLIn = 1'b1;
        Reset = 1'b1;
        #2 Reset = 1'b0;

        //                rw    addr    wdata  na    nd    done wl sh err   sent0  sent1
        vecs[0] = '{1'b0, 7'h50, 8'hCA, 1'b0, 1'b0, 320, 2, 14, 1'b0, 8'hA0, 8'hCA};
        vecs[1] = '{1'b0, 7'h50, 8'hCA, 1'b1, 1'b0, 176, 1, 7,  1'b1, 8'hA0, 8'h00};
        vecs[2] = '{1'b1, 7'h3C, 8'h55, 1'b0, 1'b0, 320, 2, 15, 1'b0, 8'h79, 8'h55};
        vecs[3] = '{1'b0, 7'h12, 8'h3F, 1'b0, 1'b1, 320, 2, 14, 1'b1, 8'h24, 8'h3F};
        vecs[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b0, 176, 1, 7,  1'b1, 8'hFF, 8'h00};

        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'(outs()), 32'(RESET_OUTS));
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (Busy !== 1'b0) busy_seen++;
        end
        chk("idle_no_busy", 32'(busy_seen), 32'(0));

        // Back-to-back: each Go is driven on the falling edge where Done is seen.
        for (int i = 0; i < 5; i++) run_txn(vecs[i], 0, 0);

        // Asynchronous reset in the middle of address bit 4.
        RW = 1'b0; Address = 7'h50; WriteData = 8'hCA; SDAIn = 1'b0; Go = 1'b1;
        @(posedge clock);
        @(negedge clock);
        Go = 1'b0;
        repeat (5 * QB + 4) @(negedge clock);
        chk("mid_busy", 32'(Busy), 32'(1));
        #2 Reset = 1'b0;
        #1 chk("mid_reset_outputs", 32'(outs()), 32'(RESET_OUTS));
        @(negedge clock);
        Reset = 1'b1;
        @(negedge clock);
        run_txn(vecs[0], 0, 0);

        // Slave holds SCL low for 10 clocks in the high phase of address bit 3.
        sv = vecs[0];
        sv.exp_done = STRETCH_DONE;
        run_txn(sv, 4 * QB + 2 * Q, 10);

        @(negedge clock);
        chk("final_idle", 32'({Busy, Done}), 32'(2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
